weight_fifo_sched: RTL and testbench
====================================

// Module: weight_fifo_sched
// PURPOSE
//  Tile-level scheduler for the weight FIFO path. For each of num_tiles tiles it fetches SYS_ROW weight
//  rows from weight memory via req/rsp, writes them into the weight FIFO, then fires the FIFO drain
//  controller once the systolic array is ready and waits for its done. Sits between the layer
//  sequencer (start/all_done) and the weight FIFO + drain controller.
// PARAMETERS
//  SYS_ROW     16  rows per tile = rows drained into the array per tile
//  FIFO_WIDTH  16  FIFO lanes; one lane per array column
//  FIFO_DEPTH  16  entries per lane; must be >= SYS_ROW (elaboration error otherwise)
//  DATA_W      16  bits per weight element
//  TILE_W       8  width of num_tiles / tile index
//  ROW_W       $clog2(SYS_ROW) (localparam)
// PORTS
//  clk           in   1                 clock, all logic on posedge
//  rst           in   1                 synchronous reset, active-high
//  start         in   1                 begin job; sampled only in IDLE
//  num_tiles     in   TILE_W            tiles in job; latched on accepted start
//  busy          out  1                 high in any state other than IDLE
//  all_done      out  1                 1-cycle pulse when last tile's drain_done is seen
//  rsp_err       out  1                 sticky: rd_rsp_valid seen outside FILL; cleared on accepted start
//  rd_req_valid  out  1                 row fetch request
//  rd_req_ready  in   1                 memory accepts request
//  rd_req_tile   out  TILE_W            tile index of request
//  rd_req_row    out  ROW_W             row index within tile
//  rd_rsp_valid  in   1                 row data returned, in request order, no backpressure
//  rd_rsp_data   in   FIFO_WIDTH*DATA_W row data, lane i = bits [i*DATA_W +: DATA_W]
//  fifo_wen      out  FIFO_WIDTH        per-lane FIFO write enable (all bits equal)
//  fifo_wdata    out  FIFO_WIDTH*DATA_W registered copy of rd_rsp_data
//  array_ready   in   1                 array has consumed prior weights, may accept new tile
//  drain_en      out  1                 1-cycle pulse starting FIFO drain controller
//  drain_done    in   1                 drain controller's last-row pulse
// BEHAVIOUR
//  Reset: state=IDLE; busy, all_done, rsp_err, rd_req_valid, fifo_wen, drain_en = 0; counters = 0.
//  Reset wins over every other input in the same cycle; reset mid-job abandons tile, no all_done.
//  States: IDLE -> FILL -> WAIT_ARR -> DRAIN -> (FILL next tile | DONE) ; DONE -> IDLE.
//  IDLE: start=1 latches num_tiles, tile_idx=0, clears rsp_err; num_tiles=0 -> DONE, else FILL.
//   start while busy is ignored (no latch, no effect).
//  FILL: rd_req_valid=1 while req_cnt<SYS_ROW; req handshake (valid&ready) increments req_cnt;
//   rd_req_row=req_cnt, rd_req_tile=tile_idx; valid stays high and addr stable until ready.
//   Each rd_rsp_valid: next cycle fifo_wen=all-ones, fifo_wdata=that data; rsp_cnt increments.
//   Request and response in same cycle both counted. Rsp beyond SYS_ROW per tile -> rsp_err, dropped.
//   Leave FILL the cycle after the write of row SYS_ROW-1 issues (rsp_cnt==SYS_ROW) -> WAIT_ARR.
//  WAIT_ARR: when array_ready=1 -> drain_en=1 for exactly one cycle (registered), enter DRAIN.
//  DRAIN: wait for drain_done; drain_done during drain_en cycle is accepted. On drain_done:
//   tile_idx==num_tiles-1 -> DONE; else tile_idx+=1, req_cnt=rsp_cnt=0, FILL.
//  DONE: all_done=1 one cycle, -> IDLE. busy low from the same cycle all_done is high.
//  drain_done outside DRAIN ignored. rd_rsp_valid outside FILL: no write, rsp_err=1.
//  No overlap: next tile's fetch starts only after current drain_done (FIFO empty).
//  Counters: req_cnt/rsp_cnt ROW_W+1 bits, saturate at SYS_ROW; tile_idx TILE_W bits, no wrap.
//  Minimum per-tile latency (ready=1, rsp 1 cycle after req, array_ready=1): SYS_ROW+4 cycles to drain_en.
// TESTING
//  1 tile, ready always 1, rsp 1 cycle after req -> rows 0..15 requested, 16 fifo_wen, 1 drain_en, all_done.
//  num_tiles=3, random rd_req_ready stalls -> each row addr held stable; tiles 0,1,2 in order; 3 drain_en.
//  num_tiles=0 -> no rd_req_valid, all_done 2 cycles after start, busy high 1 cycle only.
//  array_ready low 20 cycles after FILL -> drain_en only on first array_ready=1 cycle, never twice.
//  rst asserted mid-FILL of tile 1 -> next cycle all outputs 0, IDLE; no all_done; new start works.
//  rd_rsp_valid in IDLE -> fifo_wen stays 0, rsp_err=1 until next start; start while busy ignored.

Source files
------------

// File: rtl/weight_fifo_sched.sv
// Tile-level scheduler for the weight FIFO path: fetches SYS_ROW rows per tile into the
// weight FIFO, then hands each filled tile to the drain controller once the array is ready.
module weight_fifo_sched #(
   parameter int unsigned SYS_ROW    = 16,
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned TILE_W     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [TILE_W-1:0]            num_tiles,
   output logic                         busy,
   output logic                         all_done,
   output logic                         rsp_err,
   output logic                         rd_req_valid,
   input  logic                         rd_req_ready,
   output logic [TILE_W-1:0]            rd_req_tile,
   output logic [$clog2(SYS_ROW)-1:0]   rd_req_row,
   input  logic                         rd_rsp_valid,
   input  logic [FIFO_WIDTH*DATA_W-1:0] rd_rsp_data,
   output logic [FIFO_WIDTH-1:0]        fifo_wen,
   output logic [FIFO_WIDTH*DATA_W-1:0] fifo_wdata,
   input  logic                         array_ready,
   output logic                         drain_en,
   input  logic                         drain_done
);

   localparam int unsigned ROW_W = $clog2(SYS_ROW);
   localparam int unsigned CNT_W = ROW_W + 1;
   localparam logic [CNT_W-1:0] ROWS = CNT_W'(SYS_ROW);

   // A tile must fit entirely in the FIFO since fetch and drain never overlap
   if (FIFO_DEPTH < SYS_ROW) begin : g_depth_err
      $error("weight_fifo_sched: FIFO_DEPTH must be >= SYS_ROW");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_WAIT_ARR,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state;
   logic [TILE_W-1:0] tiles_q;
   logic [TILE_W-1:0] tile_idx;
   logic [CNT_W-1:0]  req_cnt;
   logic [CNT_W-1:0]  rsp_cnt;

   logic              req_fire_c;
   logic              last_tile_c;
   logic [CNT_W-1:0]  req_cnt_inc_c;

   assign req_fire_c    = rd_req_valid & rd_req_ready;
   assign last_tile_c   = (tile_idx == (tiles_q - TILE_W'(1)));
   assign req_cnt_inc_c = req_cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         tiles_q      <= '0;
         tile_idx     <= '0;
         req_cnt      <= '0;
         rsp_cnt      <= '0;
         busy         <= 1'b0;
         all_done     <= 1'b0;
         rsp_err      <= 1'b0;
         rd_req_valid <= 1'b0;
         rd_req_tile  <= '0;
         rd_req_row   <= '0;
         fifo_wen     <= '0;
         fifo_wdata   <= '0;
         drain_en     <= 1'b0;
      end else begin
         fifo_wen <= '0;
         drain_en <= 1'b0;
         all_done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  tiles_q     <= num_tiles;
                  tile_idx    <= '0;
                  req_cnt     <= '0;
                  rsp_cnt     <= '0;
                  rsp_err     <= 1'b0;
                  busy        <= 1'b1;
                  rd_req_tile <= '0;
                  rd_req_row  <= '0;
                  if (num_tiles == '0) begin
                     state <= S_DONE;
                  end else begin
                     state        <= S_FILL;
                     rd_req_valid <= 1'b1;
                  end
               end
            end

            S_FILL: begin
               // Address advances only on handshake; valid drops after the last row
               if (req_fire_c && (req_cnt < ROWS)) begin
                  req_cnt    <= req_cnt_inc_c;
                  rd_req_row <= ROW_W'(req_cnt_inc_c);
                  if (req_cnt_inc_c >= ROWS) begin
                     rd_req_valid <= 1'b0;
                  end
               end
               if (rd_rsp_valid) begin
                  if (rsp_cnt < ROWS) begin
                     fifo_wen   <= '1;
                     fifo_wdata <= rd_rsp_data;
                     rsp_cnt    <= rsp_cnt + CNT_W'(1);
                  end else begin
                     rsp_err <= 1'b1;
                  end
               end
               if (rsp_cnt == ROWS) begin
                  state <= S_WAIT_ARR;
               end
            end

            S_WAIT_ARR: begin
               if (array_ready) begin
                  drain_en <= 1'b1;
                  state    <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               if (drain_done) begin
                  if (last_tile_c) begin
                     state <= S_DONE;
                  end else begin
                     tile_idx     <= tile_idx + TILE_W'(1);
                     rd_req_tile  <= tile_idx + TILE_W'(1);
                     rd_req_row   <= '0;
                     req_cnt      <= '0;
                     rsp_cnt      <= '0;
                     rd_req_valid <= 1'b1;
                     state        <= S_FILL;
                  end
               end
            end

            S_DONE: begin
               all_done <= 1'b1;
               busy     <= 1'b0;
               state    <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase

         // Responses are only legal while filling; anything else is flagged and dropped
         if (rd_rsp_valid && (state != S_FILL)) begin
            rsp_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_weight_fifo_sched.sv
// Directed bench for weight_fifo_sched: table of job scenarios driven against a small
// memory / array / drain-controller model, plus hand sequences for reset and idle corners.
module tb_weight_fifo_sched;

   localparam int unsigned SYS_ROW    = 16;
   localparam int unsigned FIFO_WIDTH = 16;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned TILE_W     = 8;
   localparam int unsigned ROW_W      = 4;
   localparam int unsigned BUS_W      = FIFO_WIDTH * DATA_W;
   localparam int          BIG        = 1000000;

   logic               clk;
   logic               rst;
   logic               start;
   logic [TILE_W-1:0]  num_tiles;
   logic               busy;
   logic               all_done;
   logic               rsp_err;
   logic               rd_req_valid;
   logic               rd_req_ready;
   logic [TILE_W-1:0]  rd_req_tile;
   logic [ROW_W-1:0]   rd_req_row;
   logic               rd_rsp_valid;
   logic [BUS_W-1:0]   rd_rsp_data;
   logic [FIFO_WIDTH-1:0] fifo_wen;
   logic [BUS_W-1:0]   fifo_wdata;
   logic               array_ready;
   logic               drain_en;
   logic               drain_done;

   int checks = 0;
   int errors = 0;

   weight_fifo_sched #(
      .SYS_ROW   (SYS_ROW),
      .FIFO_WIDTH(FIFO_WIDTH),
      .FIFO_DEPTH(16),
      .DATA_W    (DATA_W),
      .TILE_W    (TILE_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_tiles   (num_tiles),
      .busy        (busy),
      .all_done    (all_done),
      .rsp_err     (rsp_err),
      .rd_req_valid(rd_req_valid),
      .rd_req_ready(rd_req_ready),
      .rd_req_tile (rd_req_tile),
      .rd_req_row  (rd_req_row),
      .rd_rsp_valid(rd_rsp_valid),
      .rd_rsp_data (rd_rsp_data),
      .fifo_wen    (fifo_wen),
      .fifo_wdata  (fifo_wdata),
      .array_ready (array_ready),
      .drain_en    (drain_en),
      .drain_done  (drain_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int num_tiles;
      int stall_pct;
      int arr_delay;
      int busy_start;
      int rst_at_req;
      int exp_reqs;
      int exp_wens;
      int exp_drains;
      int exp_first_drain;
   } vec_t;

   vec_t vecs[6];

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_bus(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [BUS_W-1:0] mk_data(input int t, input int r);
      logic [BUS_W-1:0] d;
      d = '0;
      for (int i = 0; i < int'(FIFO_WIDTH); i++) begin
         d[i*DATA_W +: DATA_W] = {8'(t), 4'(r), 4'(i)};
      end
      return d;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk_int({tag, " busy"}, int'(busy), 0);
      chk_int({tag, " all_done"}, int'(all_done), 0);
      chk_int({tag, " rsp_err"}, int'(rsp_err), 0);
      chk_int({tag, " rd_req_valid"}, int'(rd_req_valid), 0);
      chk_int({tag, " fifo_wen"}, int'(fifo_wen), 0);
      chk_int({tag, " drain_en"}, int'(drain_en), 0);
   endtask

   // One job: memory answers one cycle after each handshake, array becomes ready
   // arr_delay cycles after the last FIFO write, drain_done comes 3 cycles after drain_en.
   task automatic run_job(input vec_t v);
      int cyc, reqs, wens, drains, w_cyc, arr_ok, dd_cyc, first_drain, pt, pr, exp_d;
      bit done, pend, stall;
      logic [TILE_W-1:0] st_tile;
      logic [ROW_W-1:0]  st_row;
      cyc = 0; reqs = 0; wens = 0; drains = 0; w_cyc = 0; arr_ok = BIG; dd_cyc = -1;
      first_drain = -1; pt = 0; pr = 0; done = 1'b0; pend = 1'b0; stall = 1'b0;
      st_tile = '0; st_row = '0;
      @(negedge clk);
      start = 1'b1; num_tiles = TILE_W'(v.num_tiles);
      rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; array_ready = 1'b0; drain_done = 1'b0;
      while (!done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         start = (v.busy_start != 0) && (cyc == 5);
         if (start) num_tiles = 8'd9;
         if (cyc == 1) chk_int("rsp_err cleared by start", int'(rsp_err), 0);

         if (all_done) begin
            done = 1'b1;
            chk_int("busy at all_done", int'(busy), 0);
            chk_int("request count", reqs, v.exp_reqs);
            chk_int("fifo write count", wens, v.exp_wens);
            chk_int("drain_en count", drains, v.exp_drains);
            chk_int("rsp_err after job", int'(rsp_err), 0);
            if (v.exp_first_drain >= 0) chk_int("first drain_en cycle", first_drain, v.exp_first_drain);
         end else begin
            chk_int("busy during job", int'(busy), 1);
         end

         if (fifo_wen != '0) begin
            chk_int("fifo_wen pattern", int'(fifo_wen), 32'h0000_FFFF);
            chk_bus("fifo_wdata", fifo_wdata, mk_data(wens / 16, wens % 16));
            wens++;
            if (wens % 16 == 0) begin
               w_cyc  = cyc;
               arr_ok = cyc + v.arr_delay;
            end
         end

         if (drain_en) begin
            exp_d = ((v.arr_delay > 1) ? (w_cyc + v.arr_delay) : (w_cyc + 1)) + 1;
            chk_int("drain_en cycle", cyc, exp_d);
            if (first_drain < 0) first_drain = cyc;
            drains++;
            dd_cyc = cyc + 3;
            arr_ok = BIG;
         end

         if (stall) begin
            chk_int("valid held on stall", int'(rd_req_valid), 1);
            chk_int("tile held on stall", int'(rd_req_tile), int'(st_tile));
            chk_int("row held on stall", int'(rd_req_row), int'(st_row));
         end
         if (rd_req_valid) begin
            chk_int("rd_req_tile", int'(rd_req_tile), reqs / 16);
            chk_int("rd_req_row", int'(rd_req_row), reqs % 16);
         end

         if (v.rst_at_req >= 0 && rd_req_valid && reqs == v.rst_at_req) begin
            rst = 1'b1; start = 1'b0; rd_req_ready = 1'b0; rd_rsp_valid = 1'b0;
            array_ready = 1'b0; drain_done = 1'b0;
            @(negedge clk);
            chk_all_zero("after mid-fill reset");
            rst = 1'b0;
            repeat (10) begin
               @(negedge clk);
               chk_int("no all_done after reset", int'(all_done), 0);
               chk_int("idle after reset", int'(busy), 0);
            end
            done = 1'b1;
            break;
         end

         drain_done   = (cyc == dd_cyc);
         array_ready  = (cyc >= arr_ok);
         rd_rsp_valid = pend;
         if (pend) rd_rsp_data = mk_data(pt, pr);
         rd_req_ready = (v.stall_pct == 0) || (int'($urandom_range(0, 99)) >= v.stall_pct);
         pend  = rd_req_valid && rd_req_ready;
         stall = rd_req_valid && !rd_req_ready;
         st_tile = rd_req_tile;
         st_row  = rd_req_row;
         if (pend) begin
            pt = reqs / 16;
            pr = reqs % 16;
            reqs++;
         end
      end
      if (!done) chk_int("job completed within budget", 0, 1);
      start = 1'b0; rd_req_ready = 1'b0; rd_rsp_valid = 1'b0; array_ready = 1'b0; drain_done = 1'b0;
      @(negedge clk);
      chk_int("all_done single pulse", int'(all_done), 0);
   endtask

   initial begin
      vecs[0] = '{1, 0,  0,  0, -1, 16, 16, 1, 20};
      vecs[1] = '{3, 40, 0,  0, -1, 48, 48, 3, -1};
      vecs[2] = '{1, 0,  20, 0, -1, 16, 16, 1, 39};
      vecs[3] = '{2, 0,  0,  1, -1, 32, 32, 2, 20};
      vecs[4] = '{2, 0,  0,  0, 20, 0,  0,  0, -1};
      vecs[5] = '{1, 25, 3,  0, -1, 16, 16, 1, -1};

      rst = 1'b1; start = 1'b1; num_tiles = 8'd1;
      rd_req_ready = 1'b1; rd_rsp_valid = 1'b0; rd_rsp_data = '0;
      array_ready = 1'b1; drain_done = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset state");
      start = 1'b0; rst = 1'b0; rd_req_ready = 1'b0; array_ready = 1'b0;
      @(negedge clk);

      // Zero-tile job goes straight through DONE
      start = 1'b1; num_tiles = 8'd0;
      @(negedge clk);
      start = 1'b0;
      chk_int("zero tiles busy c1", int'(busy), 1);
      chk_int("zero tiles all_done c1", int'(all_done), 0);
      chk_int("zero tiles no request", int'(rd_req_valid), 0);
      @(negedge clk);
      chk_int("zero tiles all_done c2", int'(all_done), 1);
      chk_int("zero tiles busy c2", int'(busy), 0);
      @(negedge clk);
      chk_int("zero tiles all_done c3", int'(all_done), 0);

      // Stray response while idle
      rd_rsp_valid = 1'b1; rd_rsp_data = mk_data(7, 7);
      @(negedge clk);
      rd_rsp_valid = 1'b0;
      chk_int("idle rsp no write", int'(fifo_wen), 0);
      chk_int("idle rsp sets rsp_err", int'(rsp_err), 1);
      repeat (3) @(negedge clk);
      chk_int("rsp_err sticky", int'(rsp_err), 1);

      for (int i = 0; i < 6; i++) begin
         run_job(vecs[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
